// File: rtl/temp_seq_pkg.sv
// Shared types and constants for the temperature sample sequencer.
package temp_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    REQ,
    XFER,
    CONV,
    DONE
  } seq_state_t;

  localparam int              BIN_W   = 16;
  localparam int              DIGITS  = 4;
  localparam int              BCD_W   = 16;
  localparam logic [BIN_W-1:0] BCD_MAX = 16'd9999;

endpackage

// File: rtl/bcd_dabble16.sv
// Iterative 16-bit binary to 4-digit BCD converter (shift-add-3), one bit per clock.
// done is high in the cycle whose closing edge performs the 16th iteration;
// bcd is final from the following cycle. start is ignored while a conversion runs.
module bcd_dabble16
  import temp_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic             active;
  logic [3:0]       iter;
  logic [BIN_W-1:0] bin_sh;
  logic [BCD_W-1:0] bcd_sh;
  logic             load;

  // Add 3 to every digit that is 5 or more, so the following shift carries correctly.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int d = 0; d < DIGITS; d++) begin
      if (v[4*d +: 4] >= 4'd5) r[4*d +: 4] = v[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign load = start && !active;
  assign done = active && (iter == 4'(BIN_W - 1));
  assign bcd  = bcd_sh;

  // Iteration control: runs for exactly BIN_W clocks after an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      iter   <= '0;
    end else if (load) begin
      active <= 1'b1;
      iter   <= '0;
    end else if (active) begin
      iter <= iter + 4'd1;
      if (done) active <= 1'b0;
    end
  end

  // Datapath: load operand, then adjust-and-shift the combined register each clock.
  always_ff @(posedge clk) begin
    if (load) begin
      bin_sh <= bin;
      bcd_sh <= '0;
    end else if (active) begin
      {bcd_sh, bin_sh} <= {add3(bcd_sh), bin_sh} << 1;
    end
  end

endmodule

// File: rtl/temp_sample_sequencer.sv
// Periodic SPI temperature sampler: schedules reads, captures the frame,
// converts the low 16 bits to clamped BCD and publishes with a valid strobe.
module temp_sample_sequencer
  import temp_seq_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 1_000_000,
  parameter int SPI_TIMEOUT   = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             spi_start,
  input  logic             spi_busy,
  input  logic             spi_done,
  input  logic [23:0]      spi_data,
  output logic [BCD_W-1:0] bcd_values,
  output logic             bcd_valid,
  output logic             bcd_sat,
  output logic             timeout_err,
  output logic             overrun,
  output logic             busy
);

  localparam int                TICK_W    = $clog2(SAMPLE_PERIOD);
  localparam int                TO_W      = $clog2(SPI_TIMEOUT);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_PERIOD - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(SPI_TIMEOUT - 1);

  seq_state_t        state, state_nxt;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              pending;
  logic              enter_req;
  logic [TO_W-1:0]   to_cnt;
  logic              conv_start;
  logic              conv_done;
  logic [BCD_W-1:0]  conv_bcd;
  logic [BIN_W-1:0]  conv_bin;
  logic              sat_p0;
  logic              spi_hi_unused;

  // Values above 9999 cannot be shown in four digits; clamp rather than wrap.
  function automatic logic [BIN_W-1:0] sat_bin(input logic [BIN_W-1:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

  assign spi_hi_unused = ^spi_data[23:BIN_W];
  assign conv_bin      = sat_bin(spi_data[BIN_W-1:0]);
  assign tick          = enable && (tick_cnt == TICK_LAST);
  assign enter_req     = (state == WAIT) && enable && pending;
  // A tick landing on the same edge that consumes the pending request is not a drop.
  assign overrun       = tick && pending && !enter_req;
  assign busy          = (state != IDLE) && (state != WAIT);

  bcd_dabble16 u_dabble (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (conv_bin),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Sample-rate tick counter; held at zero while sampling is disabled.
  always_ff @(posedge clk) begin
    if (rst || !enable || tick) tick_cnt <= '0;
    else                        tick_cnt <= tick_cnt + 1'b1;
  end

  // Pending request flag: set by tick, consumed on entry to REQ, dropped when idling.
  always_ff @(posedge clk) begin
    if (rst)                                                      pending <= 1'b0;
    else if (tick)                                                pending <= 1'b1;
    else if (enter_req || state == IDLE || (state == WAIT && !enable)) pending <= 1'b0;
  end

  // SPI transaction watchdog, restarted when the request is issued.
  always_ff @(posedge clk) begin
    if (rst || state == REQ) to_cnt <= '0;
    else if (state == XFER)  to_cnt <= to_cnt + 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and strobe decode; spi_done takes priority over the watchdog.
  always_comb begin
    state_nxt   = state;
    spi_start   = 1'b0;
    timeout_err = 1'b0;
    conv_start  = 1'b0;
    case (state)
      IDLE: if (enable) state_nxt = WAIT;
      WAIT: begin
        if (!enable)      state_nxt = IDLE;
        else if (pending) state_nxt = REQ;
      end
      REQ: begin
        if (!spi_busy) begin
          spi_start = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (spi_done) begin
          conv_start = 1'b1;
          state_nxt  = CONV;
        end else if (to_cnt == TO_LAST) begin
          timeout_err = 1'b1;
          state_nxt   = WAIT;
        end
      end
      CONV:    if (conv_done) state_nxt = DONE;
      DONE:    state_nxt = WAIT;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture stage: remember whether the captured frame needed clamping.
  always_ff @(posedge clk) begin
    if (conv_start) sat_p0 <= (spi_data[BIN_W-1:0] > BCD_MAX);
  end

  // Publish stage: result, saturation level and one-cycle valid strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_values <= '0;
      bcd_sat    <= 1'b0;
      bcd_valid  <= 1'b0;
    end else begin
      bcd_valid <= (state == DONE);
      if (state == DONE) begin
        bcd_values <= conv_bcd;
        bcd_sat    <= sat_p0;
      end
    end
  end

endmodule

// File: tb/tb_temp_sample_sequencer.sv
// Directed bench for temp_sample_sequencer with a simple SPI responder model.
module tb_temp_sample_sequencer;

  localparam int P = 64;
  localparam int T = 8;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        spi_start;
  logic        spi_busy;
  logic        spi_done;
  logic [23:0] spi_data;
  logic [15:0] bcd_values;
  logic        bcd_valid;
  logic        bcd_sat;
  logic        timeout_err;
  logic        overrun;
  logic        busy;

  temp_sample_sequencer #(.SAMPLE_PERIOD(P), .SPI_TIMEOUT(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .spi_start   (spi_start),
    .spi_busy    (spi_busy),
    .spi_done    (spi_done),
    .spi_data    (spi_data),
    .bcd_values  (bcd_values),
    .bcd_valid   (bcd_valid),
    .bcd_sat     (bcd_sat),
    .timeout_err (timeout_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  int start_cnt = 0, last_start = 0, prev_start = 0;
  int valid_cnt = 0, valid_edge = 0;
  int n_to = 0, to_edge = 0;
  int n_ov = 0;
  int done_cnt = 0, done_edge = 0;
  int resp_at = -1;
  logic        model_en = 1'b0;
  logic [23:0] model_data = '0;
  logic [15:0] v_val = '0;
  logic        v_sat = 1'b0;

  logic [23:0] bnd_in  [4];
  logic [15:0] bnd_bcd [4];
  logic        bnd_sat [4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int get_cnt(input int sel);
    case (sel)
      0:       return start_cnt;
      1:       return valid_cnt;
      2:       return n_to;
      default: return done_cnt;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cnt(input string tag, input int sel, input int target, input int budget);
    int i;
    int cur;
    i   = 0;
    cur = get_cnt(sel);
    while (cur < target && i < budget) begin
      step(1);
      i++;
      cur = get_cnt(sel);
    end
    chk(tag, 32'(cur >= target), 32'd1);
  endtask

  // Output monitor at the falling edge; comb strobes seen here belong to the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (spi_start) begin
        prev_start = last_start;
        last_start = edge_n + 1;
        start_cnt++;
        if (model_en) resp_at = edge_n + 2;
      end
      if (bcd_valid) begin
        valid_cnt++;
        valid_edge = edge_n;
        v_val = bcd_values;
        v_sat = bcd_sat;
      end
      if (timeout_err) begin
        n_to++;
        to_edge = edge_n + 1;
      end
      if (overrun) n_ov++;
    end
  end

  // SPI responder: spi_done sampled two edges after spi_start.
  initial begin
    spi_done = 1'b0;
    spi_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (edge_n == resp_at) begin
        spi_done  = 1'b1;
        spi_data  = model_data;
        done_edge = edge_n + 1;
        done_cnt++;
      end else begin
        spi_done = 1'b0;
      end
    end
  end

  initial begin
    int en_edge, s_to, n0, v0, ov0, st0, e;
    bnd_in[0] = 24'h000000; bnd_bcd[0] = 16'h0000; bnd_sat[0] = 1'b0;
    bnd_in[1] = 24'h00270F; bnd_bcd[1] = 16'h9999; bnd_sat[1] = 1'b0;
    bnd_in[2] = 24'h002710; bnd_bcd[2] = 16'h9999; bnd_sat[2] = 1'b1;
    bnd_in[3] = 24'hA5FFFF; bnd_bcd[3] = 16'h9999; bnd_sat[3] = 1'b1;

    rst = 1'b1; enable = 1'b0; spi_busy = 1'b0;
    step(3);
    @(negedge clk);
    chk("rst_ctrl", 32'({spi_start, bcd_valid, bcd_sat, timeout_err, overrun, busy}), 32'd0);
    chk("rst_bcd", 32'(bcd_values), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(2);

    // capture and convert 1234
    model_en = 1'b1; model_data = 24'h0004D2;
    en_edge = edge_n; enable = 1'b1;
    wait_cnt("t1_start", 0, 1, P + 10);
    chk("t1_start_lat", 32'(last_start - en_edge), 32'(P + 2));
    wait_cnt("t1_valid", 1, 1, 40);
    chk("t1_valid_lat", 32'(valid_edge - done_edge), 32'd17);
    chk("t1_val", 32'(v_val), 32'h1234);
    chk("t1_sat", 32'(v_sat), 32'd0);
    chk("t1_pulse", 32'(bcd_valid), 32'd0);
    model_data = bnd_in[0];
    wait_cnt("t1_start2", 0, 2, P + 10);
    chk("t1_period", 32'(last_start - prev_start), 32'(P));

    // boundary values
    for (int i = 0; i < 4; i++) begin
      wait_cnt("bnd_valid", 1, 2 + i, P + 40);
      chk("bnd_val", 32'(v_val), 32'(bnd_bcd[i]));
      chk("bnd_sat", 32'(v_sat), 32'(bnd_sat[i]));
      if (i < 3) model_data = bnd_in[i + 1];
    end

    // timeout with no spi_done
    model_en = 1'b0;
    n0 = start_cnt; v0 = valid_cnt;
    wait_cnt("to_start", 0, n0 + 1, P + 10);
    s_to = last_start;
    wait_cnt("to_err", 2, 1, 20);
    chk("to_lat", 32'(to_edge - s_to), 32'(T));
    chk("to_novalid", 32'(valid_cnt), 32'(v0));
    chk("to_bcd_hold", 32'(bcd_values), 32'h9999);
    model_en = 1'b1; model_data = 24'h000063;
    wait_cnt("to_retry", 0, n0 + 2, P + 10);
    chk("to_retry_per", 32'(last_start - s_to), 32'(P));
    wait_cnt("to_retry_valid", 1, v0 + 1, 40);
    chk("to_retry_val", 32'(v_val), 32'h0099);

    // busy held across ticks
    spi_busy = 1'b1;
    ov0 = n_ov; st0 = start_cnt;
    step(4 * P);
    chk("ov_count", 32'(n_ov - ov0), 32'd2);
    chk("busy_nostart", 32'(start_cnt - st0), 32'd0);
    model_data = 24'h001E61;
    v0 = valid_cnt;
    spi_busy = 1'b0;
    step(12);
    chk("busy_release", 32'(start_cnt - st0), 32'd1);
    wait_cnt("busy_valid", 1, v0 + 1, 40);
    chk("busy_val", 32'(v_val), 32'h7777);

    // reset mid-conversion
    n0 = done_cnt;
    wait_cnt("rc_done", 3, n0 + 1, 2 * P + 40);
    e = done_edge;
    while (edge_n < e + 4) step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    model_data = 24'h000D05;
    @(negedge clk);
    chk("rc_ctrl", 32'({spi_start, bcd_valid, bcd_sat, timeout_err, overrun, busy}), 32'd0);
    chk("rc_bcd", 32'(bcd_values), 32'd0);
    v0 = valid_cnt; st0 = start_cnt;
    step(25);
    chk("rc_novalid", 32'(valid_cnt), 32'(v0));
    wait_cnt("rc_resume", 0, st0 + 1, 2 * P);
    chk("rc_resume_lat", 32'(last_start - (e + 5)), 32'(P + 2));

    // enable dropped during XFER
    enable = 1'b0;
    wait_cnt("ed_valid", 1, v0 + 1, 40);
    chk("ed_val", 32'(v_val), 32'h3333);
    st0 = start_cnt;
    step(3 * P);
    chk("ed_nostart", 32'(start_cnt - st0), 32'd0);
    chk("ed_idle", 32'(busy), 32'd0);
    en_edge = edge_n; enable = 1'b1;
    wait_cnt("ed_restart", 0, st0 + 1, P + 10);
    chk("ed_restart_lat", 32'(last_start - en_edge), 32'(P + 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
